// File: rtl/rx_huge_page_ctrl_pkg.sv
// Shared definitions for the RX huge-page write sequencer.
//   - hp_state_e   : one-hot FSM encoding (IDLE, DATA, CLOSE, SWAP, ACK)
//   - HP_HDR_QW    : qwords reserved at each page head for the status header
//   - HP_PAGE_QW   : qwords in one 2 MB huge page
//   - hp_status_word(): layout of the page-close status payload
package rx_huge_page_ctrl_pkg;

  localparam int HP_HDR_QW     = 16;
  localparam int HP_OFS_W      = 19;
  localparam int HP_PAGE_QW    = 1 << 18;
  localparam int HP_STATUS_PAD = 64 - HP_OFS_W;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_DATA  = 5'b00010,
    S_CLOSE = 5'b00100,
    S_SWAP  = 5'b01000,
    S_ACK   = 5'b10000
  } hp_state_e;

  // Status word: zero-padded qword fill offset of the page being closed.
  function automatic logic [63:0] hp_status_word(input logic [HP_OFS_W-1:0] ofs);
    return {{HP_STATUS_PAD{1'b0}}, ofs};
  endfunction

endpackage

// File: rtl/rx_huge_page_ctrl_regfile.sv
// Huge-page register file: two page base addresses, per-page ready flags,
// the active-page index and the sticky host-write error.
// Ports:
//   clk_i, rst_i      clock, async active-high reset
//   hp_wr_i/sel/addr  host page programming pulse
//   swap_i            one-cycle pulse: release the active page and flip to the other
//   base_o, ready_o   page bases and ready flags
//   active_o          index of the page being filled
//   wr_err_o          sticky: host wrote the active ready page
module rx_hp_regfile #(
  parameter int ADDR_W = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   hp_wr_i,
  input  logic                   hp_sel_i,
  input  logic [ADDR_W-1:0]      hp_addr_i,
  input  logic                   swap_i,
  output logic [1:0][ADDR_W-1:0] base_o,
  output logic [1:0]             ready_o,
  output logic                   active_o,
  output logic                   wr_err_o
);
  import rx_huge_page_ctrl_pkg::*;

  logic [1:0][ADDR_W-1:0] base_q, base_d;
  logic [1:0]             ready_q, ready_d;
  logic                   active_q, active_d;
  logic                   wr_err_q, wr_err_d;

  always_comb begin
    base_d   = base_q;
    ready_d  = ready_q;
    active_d = active_q;
    wr_err_d = wr_err_q;
    if (swap_i) begin
      ready_d[active_q] = 1'b0;
      active_d          = ~active_q;
    end
    // A host write applied after the swap clear so it wins on the page
    // being released; outside a swap the active ready page is protected.
    if (hp_wr_i) begin
      if (ready_q[hp_sel_i] && (hp_sel_i == active_q) && !swap_i) begin
        wr_err_d = 1'b1;
      end else begin
        base_d[hp_sel_i]  = hp_addr_i;
        ready_d[hp_sel_i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      base_q   <= '0;
      ready_q  <= '0;
      active_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      base_q   <= base_d;
      ready_q  <= ready_d;
      active_q <= active_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign base_o   = base_q;
  assign ready_o  = ready_q;
  assign active_o = active_q;
  assign wr_err_o = wr_err_q;

endmodule

// File: rtl/rx_huge_page_ctrl.sv
// RX huge-page write sequencer. Turns trigger / send-last / change-page
// requests into addressed commands for the TLP sender, tracks the qword fill
// offset of the active page, closes a page with a status write and swaps.
// Ports:
//   clk, reset                          clock, async active-high reset
//   hp_wr, hp_sel, hp_addr              host programs a page base
//   hp_ready, hp_active                 page ownership / page being filled
//   trigger_tlp, send_last_tlp,
//   change_huge_page, qwords_to_send    level requests, held until acked
//   trigger_tlp_ack, change_huge_page_ack  one-cycle completion pulses
//   cmd_req/addr/qwords/status/data, cmd_ack  sender handshake
//   ovf_err, hp_wr_err                  sticky error flags
module rx_huge_page_ctrl
  import rx_huge_page_ctrl_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int OFS_W  = HP_OFS_W,
  parameter int HDR_QW = HP_HDR_QW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hp_wr,
  input  logic              hp_sel,
  input  logic [ADDR_W-1:0] hp_addr,
  output logic [1:0]        hp_ready,
  output logic              hp_active,
  input  logic              trigger_tlp,
  input  logic              send_last_tlp,
  input  logic              change_huge_page,
  input  logic [4:0]        qwords_to_send,
  output logic              trigger_tlp_ack,
  output logic              change_huge_page_ack,
  output logic              cmd_req,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [4:0]        cmd_qwords,
  output logic              cmd_status,
  output logic [63:0]       cmd_data,
  input  logic              cmd_ack,
  output logic              ovf_err,
  output logic              hp_wr_err
);

  localparam int OVF_BIT = $clog2(HP_PAGE_QW);

  hp_state_e              state_q;
  logic [OFS_W-1:0]       ofs_q;
  logic [OFS_W-1:0]       ofs_d;
  logic                   last_q;   // path ends in close+swap (change ack)
  logic                   cmd_req_q, cmd_status_q;
  logic [ADDR_W-1:0]      cmd_addr_q;
  logic [4:0]             cmd_qwords_q;
  logic [63:0]            cmd_data_q;
  logic                   trig_ack_q, chg_ack_q, ovf_q;

  logic [1:0][ADDR_W-1:0] base;
  logic                   page_rdy;
  logic                   swap;

  assign page_rdy = hp_ready[hp_active];
  assign swap     = (state_q == S_SWAP);
  assign ofs_d    = ofs_q + OFS_W'(cmd_qwords_q);

  rx_hp_regfile #(.ADDR_W(ADDR_W)) u_regfile (
    .clk_i     (clk),
    .rst_i     (reset),
    .hp_wr_i   (hp_wr),
    .hp_sel_i  (hp_sel),
    .hp_addr_i (hp_addr),
    .swap_i    (swap),
    .base_o    (base),
    .ready_o   (hp_ready),
    .active_o  (hp_active),
    .wr_err_o  (hp_wr_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ofs_q        <= OFS_W'(HDR_QW);
      last_q       <= 1'b0;
      cmd_req_q    <= 1'b0;
      cmd_status_q <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_qwords_q <= '0;
      cmd_data_q   <= '0;
      trig_ack_q   <= 1'b0;
      chg_ack_q    <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (page_rdy) begin
            if (send_last_tlp || (trigger_tlp && !change_huge_page)) begin
              state_q      <= S_DATA;
              last_q       <= send_last_tlp;
              cmd_req_q    <= 1'b1;
              cmd_status_q <= 1'b0;
              cmd_addr_q   <= base[hp_active] + ADDR_W'({ofs_q, 3'b000});
              cmd_qwords_q <= qwords_to_send;
            end else if (change_huge_page) begin
              state_q <= S_CLOSE;
              last_q  <= 1'b1;
            end
          end
        end
        S_DATA: begin
          if (cmd_ack) begin
            cmd_req_q <= 1'b0;
            ofs_q     <= ofs_d;
            // Past the page end: flag it, but the command already went out.
            if (ofs_d[OVF_BIT]) ovf_q <= 1'b1;
            state_q   <= last_q ? S_CLOSE : S_ACK;
          end
        end
        S_CLOSE: begin
          // First cycle loads the status command so cmd_req drops for a
          // cycle between the last data command and the status write.
          if (!cmd_req_q) begin
            cmd_req_q    <= 1'b1;
            cmd_status_q <= 1'b1;
            cmd_addr_q   <= base[hp_active];
            cmd_qwords_q <= 5'd1;
            cmd_data_q   <= hp_status_word(ofs_q);
          end else if (cmd_ack) begin
            cmd_req_q <= 1'b0;
            state_q   <= S_SWAP;
          end
        end
        S_SWAP: begin
          ofs_q   <= OFS_W'(HDR_QW);
          state_q <= S_ACK;
        end
        S_ACK: begin
          // Two cycles: raise the pulse, then drop it and return to IDLE
          // only after the requester has seen the ack.
          if (!(trig_ack_q || chg_ack_q)) begin
            if (last_q) chg_ack_q  <= 1'b1;
            else        trig_ack_q <= 1'b1;
          end else begin
            trig_ack_q <= 1'b0;
            chg_ack_q  <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_req              = cmd_req_q;
  assign cmd_addr             = cmd_addr_q;
  assign cmd_qwords           = cmd_qwords_q;
  assign cmd_status           = cmd_status_q;
  assign cmd_data             = cmd_data_q;
  assign trigger_tlp_ack      = trig_ack_q;
  assign change_huge_page_ack = chg_ack_q;
  assign ovf_err              = ovf_q;

endmodule

// File: tb/tb_rx_huge_page_ctrl.sv
module tb_rx_huge_page_ctrl;
  localparam int AW      = 64;
  localparam int PAGE_QW = 1 << 18;

  logic          clk = 1'b0;
  logic          reset;
  logic          hp_wr, hp_sel;
  logic [AW-1:0] hp_addr;
  logic [1:0]    hp_ready;
  logic          hp_active;
  logic          trigger_tlp, send_last_tlp, change_huge_page;
  logic [4:0]    qwords_to_send;
  logic          trigger_tlp_ack, change_huge_page_ack;
  logic          cmd_req;
  logic [AW-1:0] cmd_addr;
  logic [4:0]    cmd_qwords;
  logic          cmd_status;
  logic [63:0]   cmd_data;
  logic          cmd_ack;
  logic          ovf_err, hp_wr_err;

  always #5 clk = ~clk;

  rx_huge_page_ctrl dut (
    .clk(clk), .reset(reset),
    .hp_wr(hp_wr), .hp_sel(hp_sel), .hp_addr(hp_addr),
    .hp_ready(hp_ready), .hp_active(hp_active),
    .trigger_tlp(trigger_tlp), .send_last_tlp(send_last_tlp),
    .change_huge_page(change_huge_page), .qwords_to_send(qwords_to_send),
    .trigger_tlp_ack(trigger_tlp_ack), .change_huge_page_ack(change_huge_page_ack),
    .cmd_req(cmd_req), .cmd_addr(cmd_addr), .cmd_qwords(cmd_qwords),
    .cmd_status(cmd_status), .cmd_data(cmd_data), .cmd_ack(cmd_ack),
    .ovf_err(ovf_err), .hp_wr_err(hp_wr_err)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: page table, fill offset in qwords, sticky flags.
  logic [63:0] m_base [2];
  bit   [1:0]  m_rdy;
  int          m_act;
  longint      m_ofs;
  bit          m_ovf, m_wrerr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_rdy = 2'b00; m_act = 0; m_ofs = 16; m_ovf = 0; m_wrerr = 0;
    m_base[0] = '0; m_base[1] = '0;
  endtask

  task automatic m_host(input int sel, input logic [63:0] a);
    if (m_rdy[sel] && sel == m_act) m_wrerr = 1;
    else begin m_base[sel] = a; m_rdy[sel] = 1'b1; end
  endtask

  // Called and returns at a negedge.
  task automatic host_wr(input int sel, input logic [63:0] a);
    hp_wr = 1'b1; hp_sel = sel[0]; hp_addr = a;
    @(negedge clk);
    hp_wr = 1'b0;
    m_host(sel, a);
  endtask

  function automatic logic [63:0] rnd_base();
    logic [63:0] r;
    r = {32'($urandom), 32'($urandom)};
    r[20:0] = '0;
    return r;
  endfunction

  // Wait for a command, check it, hold it dly cycles (optional host write
  // in the middle), then acknowledge it.
  task automatic serve_cmd(input string tag, input bit st, input logic [63:0] ea,
                           input int eq, input logic [63:0] ed, input int dly,
                           input bit mid_wr, input int mid_sel, input logic [63:0] mid_a);
    bit bad;
    for (int i = 0; i < 20 && !cmd_req; i++) @(negedge clk);
    chk({tag, "_req"}, cmd_req, 1);
    chk({tag, "_addr"}, cmd_addr, ea);
    chk({tag, "_qw"}, cmd_qwords, eq);
    chk({tag, "_status"}, cmd_status, st);
    if (st) chk({tag, "_data"}, cmd_data, ed);
    bad = 0;
    for (int k = 0; k < dly; k++) begin
      if (mid_wr && k == dly / 2) begin hp_wr = 1'b1; hp_sel = mid_sel[0]; hp_addr = mid_a; end
      @(negedge clk);
      hp_wr = 1'b0;
      if (cmd_req !== 1'b1 || cmd_addr !== ea || cmd_qwords !== eq[4:0]) bad = 1;
    end
    if (mid_wr) m_host(mid_sel, mid_a);
    if (dly > 0) chk({tag, "_stable"}, bad, 0);
    cmd_ack = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
    chk({tag, "_req_drop"}, cmd_req, 0);
  endtask

  task automatic wait_ack(input bit chg);
    for (int i = 0; i < 8 && !(chg ? change_huge_page_ack : trigger_tlp_ack); i++) @(negedge clk);
    chk(chg ? "chg_ack" : "trig_ack", chg ? change_huge_page_ack : trigger_tlp_ack, 1);
    chk("other_ack", chg ? trigger_tlp_ack : change_huge_page_ack, 0);
    trigger_tlp = 0; send_last_tlp = 0; change_huge_page = 0;
    @(negedge clk);
    chk("ack_single", {trigger_tlp_ack, change_huge_page_ack}, 0);
    chk("ovf_err", ovf_err, m_ovf);
    chk("hp_wr_err", hp_wr_err, m_wrerr);
  endtask

  task automatic add_ofs(input int q);
    m_ofs += q;
    if (m_ofs >= PAGE_QW) m_ovf = 1;
  endtask

  task automatic do_trigger(input int q, input int dly, input bit mid_wr,
                            input int mid_sel, input logic [63:0] mid_a);
    logic [63:0] ea;
    ea = m_base[m_act] + 64'(m_ofs) * 8;
    trigger_tlp = 1'b1; qwords_to_send = q[4:0];
    @(negedge clk);
    serve_cmd("trig", 0, ea, q, 0, dly, mid_wr, mid_sel, mid_a);
    add_ofs(q);
    wait_ack(0);
  endtask

  task automatic do_close(input bit with_data, input int q, input int dly);
    logic [63:0] ea;
    if (with_data) begin send_last_tlp = 1'b1; qwords_to_send = q[4:0]; end
    else change_huge_page = 1'b1;
    @(negedge clk);
    if (with_data) begin
      ea = m_base[m_act] + 64'(m_ofs) * 8;
      serve_cmd("last_data", 0, ea, q, 0, dly, 0, 0, 0);
      add_ofs(q);
    end
    serve_cmd("close", 1, m_base[m_act], 1, 64'(m_ofs), dly, 0, 0, 0);
    m_rdy[m_act] = 1'b0; m_act ^= 1; m_ofs = 16;
    wait_ack(1);
    chk("hp_active", hp_active, m_act);
    chk("hp_ready", hp_ready, m_rdy);
  endtask

  initial begin
    bit bad;
    int cnt, op;
    hp_wr = 0; hp_sel = 0; hp_addr = '0;
    trigger_tlp = 0; send_last_tlp = 0; change_huge_page = 0;
    qwords_to_send = 5'd1; cmd_ack = 0;
    m_reset();
    reset = 1'b1;
    #1;
    chk("rst_cmd", {cmd_req, cmd_status, cmd_qwords}, 0);
    chk("rst_addr", cmd_addr, 0);
    chk("rst_data", cmd_data, 0);
    chk("rst_acks", {trigger_tlp_ack, change_huge_page_ack}, 0);
    chk("rst_pages", {hp_ready, hp_active}, 0);
    chk("rst_err", {ovf_err, hp_wr_err}, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Request held with no page programmed: nothing happens.
    trigger_tlp = 1'b1; qwords_to_send = 5'd16;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (cmd_req || trigger_tlp_ack || change_huge_page_ack) bad = 1;
    end
    chk("no_page_idle", bad, 0);
    host_wr(0, 64'h1000_0000);
    for (int i = 0; i < 2 && !cmd_req; i++) @(negedge clk);
    chk("req_within_2", cmd_req, 1);
    serve_cmd("first", 0, 64'h1000_0080, 16, 0, 0, 0, 0, 0);
    add_ofs(16);
    wait_ack(0);
    host_wr(1, 64'h2000_0000);

    // Exact latency with an immediate sender ack.
    trigger_tlp = 1'b1; qwords_to_send = 5'd16; cmd_ack = 1'b1;
    @(negedge clk);
    chk("lat_c1_req", cmd_req, 1);
    chk("lat_c1_addr", cmd_addr, 64'h1000_0100);
    @(negedge clk);
    chk("lat_c2", {cmd_req, trigger_tlp_ack}, 0);
    @(negedge clk);
    chk("lat_c3_ack", trigger_tlp_ack, 1);
    trigger_tlp = 0; cmd_ack = 0;
    @(negedge clk);
    chk("lat_c4_ack", trigger_tlp_ack, 0);
    add_ofs(16);

    // Slow sender with a host write to the inactive page mid-wait.
    do_trigger(16, 50, 1, 1, 64'h2400_0000);
    chk("no_wr_err", hp_wr_err, 0);

    // Close page 0 with a 5-qword tail: data at +0x200, status 0x45.
    do_close(1, 5, 2);
    chk("swap_ready", hp_ready, 2'b10);
    chk("swap_active", hp_active, 1);
    do_trigger(4, 0, 0, 0, 0);

    // Randomized traffic against the model.
    for (int it = 0; it < 40; it++) begin
      op = int'($urandom_range(0, 9));
      if (op < 6) begin
        do_trigger(int'($urandom_range(1, 16)), int'($urandom_range(0, 3)),
                   op == 0, m_act ^ 1, rnd_base());
      end else if (op < 8) begin
        host_wr(m_act ^ 1, rnd_base());
      end else begin
        if (!m_rdy[m_act ^ 1]) host_wr(m_act ^ 1, rnd_base());
        do_close(op == 9, int'($urandom_range(1, 16)), int'($urandom_range(0, 2)));
      end
    end

    // Empty page close twice in a row: status count is the header size.
    if (!m_rdy[m_act ^ 1]) host_wr(m_act ^ 1, 64'h3000_0000);
    do_close(0, 1, 0);
    host_wr(m_act ^ 1, 64'h4000_0000);
    do_close(0, 1, 0);
    host_wr(m_act ^ 1, 64'h5000_0000);

    // Fill the fresh page to 0x3FFF0 with back-to-back 16-qword TLPs.
    trigger_tlp = 1'b1; qwords_to_send = 5'd16; cmd_ack = 1'b1; cnt = 0;
    for (int c = 0; c < 70000 && cnt < 16382; c++) begin
      @(negedge clk);
      if (trigger_tlp_ack) begin
        cnt++;
        if (cnt == 16382) begin trigger_tlp = 0; cmd_ack = 0; end
      end
    end
    trigger_tlp = 0; cmd_ack = 0;
    chk("fill_count", cnt, 16382);
    m_ofs += 64'(16 * 16382);
    @(negedge clk);
    do_trigger(8, 0, 0, 0, 0);
    chk("ofs_pre_ovf", ovf_err, 0);
    do_trigger(16, 1, 0, 0, 0);
    chk("ovf_set", ovf_err, 1);
    do_trigger(3, 0, 0, 0, 0);
    host_wr(m_act, 64'h7777_0000);
    chk("wr_err_set", hp_wr_err, 1);
    do_trigger(1, 0, 0, 0, 0);

    // Async reset while the status write is pending.
    change_huge_page = 1'b1;
    for (int i = 0; i < 20 && !cmd_req; i++) @(negedge clk);
    chk("close_pending", {cmd_req, cmd_status}, 2'b11);
    reset = 1'b1;
    #1;
    chk("arst_req", cmd_req, 0);
    chk("arst_acks", {trigger_tlp_ack, change_huge_page_ack}, 0);
    chk("arst_pages", {hp_ready, hp_active}, 0);
    chk("arst_err", {ovf_err, hp_wr_err}, 0);
    @(negedge clk);
    reset = 1'b0; change_huge_page = 0;
    m_reset();
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (cmd_req || trigger_tlp_ack || change_huge_page_ack) bad = 1;
    end
    chk("post_rst_quiet", bad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
